// File: rtl/regfile_pkg.sv
// Shared defaults and port-slice helper for the multi-read-port register file.
package regfile_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 4;
   localparam int unsigned NUM_RD_DEF = 2;

   // Low bit of lane idx in a flattened bus of w-bit lanes
   function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
      return idx * w;
   endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read lane: address mux over the shared array, write bypass
// and hardwired-zero override, then the enabled output register.
module regfile_rd_port #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] mem [2**ADDR_W],
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data
);

   logic              wr_hit_c;
   logic [DATA_W-1:0] rd_next_c;

   // Zero override is applied last so a colliding write to entry 0 never leaks through
   always_comb begin
      wr_hit_c  = wr_en && (wr_addr == rd_addr);
      rd_next_c = mem[rd_addr];
      if ((BYPASS != 0) && wr_hit_c) begin
         rd_next_c = wr_data;
      end
      if ((ZERO_REG != 0) && (rd_addr == ADDR_W'(0))) begin
         rd_next_c = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= rd_next_c;
      end
   end

endmodule

// File: rtl/regfile_nr1w.sv
// NUM_RD-read / 1-write register file over a single resettable flop array,
// with registered read data, optional zero entry and optional write bypass.
module regfile_nr1w
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned NUM_RD   = NUM_RD_DEF,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_drop_c;
   logic              wr_go_c;

   // Writes to entry 0 are discarded when it is hardwired to zero
   always_comb begin
      wr_drop_c = (ZERO_REG != 0) && (wr_addr == ADDR_W'(0));
      wr_go_c   = wr_en && !wr_drop_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned e = 0; e < DEPTH; e++) begin
            mem[e] <= '0;
         end
      end else if (wr_go_c) begin
         mem[wr_addr] <= wr_data;
      end
   end

   for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
      regfile_rd_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_rd_port (
         .clk     (clk),
         .rst     (rst),
         .rd_en   (rd_en[i]),
         .rd_addr (rd_addr[slice_lo(i, ADDR_W) +: ADDR_W]),
         .mem     (mem),
         .wr_en   (wr_go_c),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .rd_data (rd_data[slice_lo(i, DATA_W) +: DATA_W])
      );
   end

endmodule
